game_tick_scheduler: RTL and testbench

- Master timing and sequencing controller for the game core. Runs from the 100 MHz board clock.
- Generates the 25 MHz pixel enable and a programmable-rate game tick.
- On each game tick, runs the actor update phases strictly in order (e.g. player, bullets, aliens, collision) over a req/ack handshake, so update logic never overlaps.
- Flags overruns and unresponsive phases.

---
 rtl/game_tick_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
//   Master timing and sequencing controller for the game core.
//   - 1-in-4 pixel clock enable derived from the master clock.
//   - Programmable-rate game tick: period = (CLK_HZ/TICK_HZ) >> speed.
//   - On each tick, runs NUM_PHASES update phases strictly in order over a
//     req/ack handshake, with one dead cycle between phases so update logic
//     never overlaps. A phase holding req for ACK_TIMEOUT cycles without ack
//     is skipped and flagged.
//   Optional feature (macro SCHED_STEP_EN): pause freezes the tick divider,
//   and a step pulse while paused and idle fires exactly one tick. Without
//   the macro, pause and step are accepted but ignored.
//
// Ports:
//   clk          in   master clock
//   rst          in   synchronous active-high reset
//   speed[1:0]   in   tick rate select (period = BASE_DIV >> speed)
//   pause        in   level, freezes divider (SCHED_STEP_EN only)
//   step         in   1-cycle pulse, one tick while paused (SCHED_STEP_EN only)
//   phase_ack    in   per-phase completion (pulse or level)
//   pix_en       out  1-in-4 pixel enable, registered
//   phase_req    out  one-hot request to the active phase, else 0
//   frame_busy   out  high while any phase is in progress
//   frame_done   out  1-cycle pulse after the last phase
//   tick_count   out  completed frames, wraps at 16 bits
//   tick_overrun out  sticky: tick arrived while a frame was running
//   timeout_err  out  sticky: some phase timed out
module game_tick_scheduler #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned TICK_HZ     = 10,
  parameter int unsigned NUM_PHASES  = 4,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            speed,
  input  logic                  pause,
  input  logic                  step,
  input  logic [NUM_PHASES-1:0] phase_ack,
  output logic                  pix_en,
  output logic [NUM_PHASES-1:0] phase_req,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [15:0]           tick_count,
  output logic                  tick_overrun,
  output logic                  timeout_err
);

  localparam int unsigned BASE_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned DW = $clog2(BASE_DIV);
  localparam int unsigned PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  // S_GAP is the single dead cycle between consecutive phases.
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [1:0]      r_pix_cnt;
  logic            r_pix_en;
  logic [DW-1:0]   r_div_cnt;
  logic [PW-1:0]   r_phase;
  logic [TW-1:0]   r_to_cnt;
  logic [15:0]     r_tick_count;
  logic            r_overrun;
  logic            r_timeout;

  logic [DW-1:0]   w_period_m1;
  logic            w_div_tick;
  logic            w_div_hold;
  logic            w_tick;
  logic            w_ack;
  logic            w_to;
  logic            w_advance;
  logic            w_last;

  // ---------------------------------------------------------------
  // Pixel enable
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else begin
      r_pix_cnt <= r_pix_cnt + 2'd1;
      r_pix_en  <= (r_pix_cnt == 2'd3);
    end
  end

  assign pix_en = r_pix_en;

  // ---------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------
  assign w_period_m1 = DW'((BASE_DIV >> speed) - 32'd1);
  // >= rather than == so a speed-up that leaves the count beyond the new
  // terminal value ticks immediately instead of running to wrap-around.
  assign w_div_tick  = (r_div_cnt >= w_period_m1);

`ifdef SCHED_STEP_EN
  assign w_div_hold = pause;
  assign w_tick     = pause ? (step && (r_state == S_IDLE)) : w_div_tick;
`else
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, pause, step};
  assign w_div_hold  = 1'b0;
  assign w_tick      = w_div_tick;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!w_div_hold) begin
      if (w_div_tick) r_div_cnt <= '0;
      else            r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Phase sequencer
  // ---------------------------------------------------------------
  assign w_ack     = phase_ack[r_phase];
  assign w_to      = (r_to_cnt == TW'(ACK_TIMEOUT - 1));
  assign w_advance = (r_state == S_REQ) && (w_ack || w_to);
  assign w_last    = (r_phase == PW'(NUM_PHASES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_tick) w_next_state = S_REQ;
      S_REQ:  if (w_advance) w_next_state = w_last ? S_DONE : S_GAP;
      S_GAP:  w_next_state = S_REQ;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    phase_req  = '0;
    frame_busy = 1'b0;
    frame_done = 1'b0;
    unique case (r_state)
      S_REQ: begin
        phase_req  = NUM_PHASES'(1) << r_phase;
        frame_busy = 1'b1;
      end
      S_GAP:  frame_busy = 1'b1;
      S_DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: phase index, per-phase timeout counter, frame counter, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= '0;
      r_to_cnt     <= '0;
      r_tick_count <= '0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_tick)
        r_phase <= '0;
      else if (w_advance && !w_last)
        r_phase <= r_phase + PW'(1);

      if ((r_state == S_REQ) && !w_advance) r_to_cnt <= r_to_cnt + TW'(1);
      else                                  r_to_cnt <= '0;

      // Count moves on entering DONE so it is current while frame_done is high.
      if (w_advance && w_last) r_tick_count <= r_tick_count + 16'd1;

      // Ack wins over a simultaneous timeout.
      if ((r_state == S_REQ) && !w_ack && w_to) r_timeout <= 1'b1;

      if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign tick_count   = r_tick_count;
  assign tick_overrun = r_overrun;
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_game_tick_scheduler.sv
module tb_game_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  speed;
  logic        pause;
  logic        step;
  logic [3:0]  phase_ack;
  logic        pix_en;
  logic [3:0]  phase_req;
  logic        frame_busy;
  logic        frame_done;
  logic [15:0] tick_count;
  logic        tick_overrun;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  game_tick_scheduler #(
    .CLK_HZ      (1000),
    .TICK_HZ     (10),
    .NUM_PHASES  (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .speed        (speed),
    .pause        (pause),
    .step         (step),
    .phase_ack    (phase_ack),
    .pix_en       (pix_en),
    .phase_req    (phase_req),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .tick_count   (tick_count),
    .tick_overrun (tick_overrun),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Entered with req for phase p visible; acks after dly further cycles and
  // returns on the cycle after the ack was sampled.
  task automatic do_phase(input int p, input int dly);
    logic [3:0] m;
    m = 4'b0001 << p;
    check("req_on", 32'(phase_req), 32'(m));
    for (int k = 0; k < dly; k++) begin
      tick();
      check("req_hold", 32'(phase_req), 32'(m));
    end
    phase_ack = m;
    tick();
    phase_ack = '0;
    check("req_drop", 32'(phase_req), 32'd0);
  endtask

  task automatic finish_last(input int exp_cnt);
    check("frame_done", 32'(frame_done), 32'd1);
    check("busy_done", 32'(frame_busy), 32'd0);
    check("tick_count", 32'(tick_count), 32'(exp_cnt));
    tick();
    check("frame_done_pulse", 32'(frame_done), 32'd0);
  endtask

  task automatic run_frame(input int dly, input int exp_cnt);
    for (int p = 0; p < 4; p++) begin
      do_phase(p, dly);
      if (p < 3) begin
        check("busy_gap", 32'(frame_busy), 32'd1);
        tick();
      end
    end
    finish_last(exp_cnt);
  endtask

  task automatic wait_for_req(input int exp_cycle, input int limit);
    int n;
    n = 0;
    while (phase_req == 4'd0 && n < limit) begin
      tick();
      n++;
    end
    check("start_cycle", 32'(cyc), 32'(exp_cycle));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int held;
    int bad;
    int start;
    rst = 1'b1; speed = 2'd0; pause = 1'b0; step = 1'b0; phase_ack = '0;
    repeat (3) tick();
    check("rst_req", 32'(phase_req), 32'd0);
    check("rst_pix", 32'(pix_en), 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_count", 32'(tick_count), 32'd0);
    check("rst_flags", 32'({tick_overrun, timeout_err, frame_done}), 32'd0);

    // Pixel enable cadence and first tick at cycle 100.
    rst = 1'b0; cyc = 0;
    for (int n = 1; n < 100; n++) begin
      tick();
      check("pix_en", 32'(pix_en), ((n % 4) == 0) ? 32'd1 : 32'd0);
      check("idle_req", 32'(phase_req), 32'd0);
    end
    wait_for_req(100, 10);
    check("pix_at_100", 32'(pix_en), 32'd1);
    check("busy_with_req", 32'(frame_busy), 32'd1);

    // Frame 1: every phase acks 2 cycles after its req.
    run_frame(2, 1);
    check("f1_overrun", 32'(tick_overrun), 32'd0);
    check("f1_timeout", 32'(timeout_err), 32'd0);

    // Frame 2: phase 2 never acks and must be held exactly 8 cycles.
    wait_for_req(200, 150);
    do_phase(0, 2); check("busy_gap", 32'(frame_busy), 32'd1); tick();
    do_phase(1, 2); check("busy_gap", 32'(frame_busy), 32'd1); tick();
    check("req2_on", 32'(phase_req), 32'b0100);
    held = 1;
    while (phase_req == 4'b0100 && held < 20) begin
      tick();
      if (phase_req == 4'b0100) held++;
    end
    check("req2_held", 32'(held), 32'd8);
    check("timeout_set", 32'(timeout_err), 32'd1);
    check("timeout_req_drop", 32'(phase_req), 32'd0);
    check("timeout_busy", 32'(frame_busy), 32'd1);
    tick();
    do_phase(3, 2);
    finish_last(2);

    // Frame 3: period 25, long phases so a tick lands mid-frame.
    speed = 2'd2;
    wait_for_req(225, 20);
    run_frame(6, 3);
    check("overrun_set", 32'(tick_overrun), 32'd1);
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    wait_for_req(275, 40);
    run_frame(2, 4);

    // Frame 5: reset during phase 1.
    wait_for_req(300, 20);
    do_phase(0, 2); check("busy_gap", 32'(frame_busy), 32'd1); tick();
    check("req1_before_rst", 32'(phase_req), 32'b0010);
    rst = 1'b1; speed = 2'd0;
    tick();
    check("midrst_req", 32'(phase_req), 32'd0);
    check("midrst_busy", 32'(frame_busy), 32'd0);
    check("midrst_count", 32'(tick_count), 32'd0);
    check("midrst_flags", 32'({tick_overrun, timeout_err}), 32'd0);
    rst = 1'b0; cyc = 0;
    wait_for_req(100, 150);

    // Ack lands on the same cycle the timeout would fire: no error.
    run_frame(7, 1);
    check("ack_at_timeout", 32'(timeout_err), 32'd0);

    // Speed-up leaving div_cnt beyond the new terminal value ticks at once.
    speed = 2'd2;
    wait_for_req(137, 5);
    run_frame(2, 2);
    check("no_overrun", 32'(tick_overrun), 32'd0);

`ifdef SCHED_STEP_EN
    pause = 1'b1;
    bad = 0;
    for (int n = 0; n < 500; n++) begin
      tick();
      if (phase_req != 4'd0) bad++;
    end
    check("pause_noreq", 32'(bad), 32'd0);
    step = 1'b1; tick(); step = 1'b0;
    do_phase(0, 2); check("busy_gap", 32'(frame_busy), 32'd1);
    step = 1'b1; tick(); step = 1'b0;
    do_phase(1, 2); check("busy_gap", 32'(frame_busy), 32'd1); tick();
    do_phase(2, 2); check("busy_gap", 32'(frame_busy), 32'd1); tick();
    do_phase(3, 2);
    finish_last(3);
    check("step_busy_no_overrun", 32'(tick_overrun), 32'd0);
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (phase_req != 4'd0) bad++;
    end
    check("step_single_frame", 32'(bad), 32'd0);
    pause = 1'b0;
    start = cyc;
    wait_for_req(start + 9, 20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
